// File: rtl/hazard_ctrl.sv
// Five-stage MIPS hazard controller: tracks in-flight destinations through E/M/W
// and derives the D-stage stall/bubble plus the operand forwarding selects.
module hazard_ctrl #(
    parameter logic [1:0] TUSE_NONE   = 2'b11,
    parameter bit         MD_STALL_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Tuse_rs,
    input  logic [1:0] Tuse_rt,
    input  logic [1:0] TnewD,
    input  logic [4:0] A_rsD,
    input  logic [4:0] A_rtD,
    input  logic [4:0] AwriteD,
    input  logic       md_useD,
    input  logic       md_startE,
    input  logic       md_busy,
    output logic       stall,
    output logic [1:0] fwd_rsD,
    output logic [1:0] fwd_rtD,
    output logic [1:0] fwd_rsE,
    output logic [1:0] fwd_rtE,
    output logic       fwd_rtM,
    output logic [4:0] A_writeE,
    output logic [4:0] A_writeM,
    output logic [4:0] A_writeW
);

    logic [4:0] r_A_writeE, r_A_writeM, r_A_writeW;
    logic [1:0] r_TnewE, r_TnewM;
    logic [4:0] r_A_rsE, r_A_rtE, r_A_rtM;

    logic w_rsHitE, w_rsHitM, w_rtHitE, w_rtHitM;
    logic w_rsEHitM, w_rsEHitW, w_rtEHitM, w_rtEHitW;
    logic w_stallRs, w_stallRt, w_stallMd;

    function automatic logic [1:0] satDec(input logic [1:0] x);
        return (x == 2'd0) ? 2'd0 : x - 2'd1;
    endfunction

    // Register $0 is hard-wired to zero, so it can never be a hazard source.
    function automatic logic isHit(input logic [4:0] addr, input logic [4:0] dst);
        return (addr != 5'd0) && (addr == dst);
    endfunction

    assign w_rsHitE  = isHit(A_rsD, r_A_writeE);
    assign w_rsHitM  = isHit(A_rsD, r_A_writeM);
    assign w_rtHitE  = isHit(A_rtD, r_A_writeE);
    assign w_rtHitM  = isHit(A_rtD, r_A_writeM);
    assign w_rsEHitM = isHit(r_A_rsE, r_A_writeM);
    assign w_rsEHitW = isHit(r_A_rsE, r_A_writeW);
    assign w_rtEHitM = isHit(r_A_rtE, r_A_writeM);
    assign w_rtEHitW = isHit(r_A_rtE, r_A_writeW);

    assign w_stallRs = (Tuse_rs != TUSE_NONE) &&
                       ((w_rsHitE && (r_TnewE > Tuse_rs)) || (w_rsHitM && (r_TnewM > Tuse_rs)));
    assign w_stallRt = (Tuse_rt != TUSE_NONE) &&
                       ((w_rtHitE && (r_TnewE > Tuse_rt)) || (w_rtHitM && (r_TnewM > Tuse_rt)));
    assign w_stallMd = MD_STALL_EN && md_useD && (md_busy || md_startE);

    always_comb begin
        stall   = w_stallRs || w_stallRt || w_stallMd;
        fwd_rsD = 2'd0;
        fwd_rtD = 2'd0;
        fwd_rsE = 2'd0;
        fwd_rtE = 2'd0;
        // Youngest ready producer wins when several stages hold the same register.
        if (w_rsHitE && (r_TnewE == 2'd0)) begin
            fwd_rsD = 2'd1;
        end else if (w_rsHitM && (r_TnewM == 2'd0)) begin
            fwd_rsD = 2'd2;
        end
        if (w_rtHitE && (r_TnewE == 2'd0)) begin
            fwd_rtD = 2'd1;
        end else if (w_rtHitM && (r_TnewM == 2'd0)) begin
            fwd_rtD = 2'd2;
        end
        if (w_rsEHitM && (r_TnewM == 2'd0)) begin
            fwd_rsE = 2'd1;
        end else if (w_rsEHitW) begin
            fwd_rsE = 2'd2;
        end
        if (w_rtEHitM && (r_TnewM == 2'd0)) begin
            fwd_rtE = 2'd1;
        end else if (w_rtEHitW) begin
            fwd_rtE = 2'd2;
        end
        fwd_rtM = isHit(r_A_rtM, r_A_writeW);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_A_writeE <= 5'd0;
            r_TnewE    <= 2'd0;
            r_A_rsE    <= 5'd0;
            r_A_rtE    <= 5'd0;
            r_A_writeM <= 5'd0;
            r_TnewM    <= 2'd0;
            r_A_rtM    <= 5'd0;
            r_A_writeW <= 5'd0;
        end else begin
            // A stalled D instruction leaves a bubble in E rather than a duplicate.
            if (stall) begin
                r_A_writeE <= 5'd0;
                r_TnewE    <= 2'd0;
                r_A_rsE    <= 5'd0;
                r_A_rtE    <= 5'd0;
            end else begin
                r_A_writeE <= AwriteD;
                r_TnewE    <= satDec(TnewD);
                r_A_rsE    <= A_rsD;
                r_A_rtE    <= A_rtD;
            end
            r_A_writeM <= r_A_writeE;
            r_TnewM    <= satDec(r_TnewE);
            r_A_rtM    <= r_A_rtE;
            r_A_writeW <= r_A_writeM;
        end
    end

    assign A_writeE = r_A_writeE;
    assign A_writeM = r_A_writeM;
    assign A_writeW = r_A_writeW;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, reset corner cases,
// then randomized traffic compared against an age-based pipeline model.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] tuseRs, tuseRt, tnewD;
    logic [4:0] rsD, rtD, wrD;
    logic       mdUseD, mdStartE, mdBusy;

    logic       stall;
    logic [1:0] fwdRsD, fwdRtD, fwdRsE, fwdRtE;
    logic       fwdRtM;
    logic [4:0] aWriteE, aWriteM, aWriteW;

    logic       nStall;
    logic [1:0] nFwdRsD, nFwdRtD, nFwdRsE, nFwdRtE;
    logic       nFwdRtM;
    logic [4:0] nWriteE, nWriteM, nWriteW;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.TUSE_NONE(2'b11), .MD_STALL_EN(1'b1)) u_dut (
        .clk(clk), .reset(reset),
        .Tuse_rs(tuseRs), .Tuse_rt(tuseRt), .TnewD(tnewD),
        .A_rsD(rsD), .A_rtD(rtD), .AwriteD(wrD),
        .md_useD(mdUseD), .md_startE(mdStartE), .md_busy(mdBusy),
        .stall(stall), .fwd_rsD(fwdRsD), .fwd_rtD(fwdRtD),
        .fwd_rsE(fwdRsE), .fwd_rtE(fwdRtE), .fwd_rtM(fwdRtM),
        .A_writeE(aWriteE), .A_writeM(aWriteM), .A_writeW(aWriteW)
    );

    hazard_ctrl #(.TUSE_NONE(2'b11), .MD_STALL_EN(1'b0)) u_noMd (
        .clk(clk), .reset(reset),
        .Tuse_rs(tuseRs), .Tuse_rt(tuseRt), .TnewD(tnewD),
        .A_rsD(rsD), .A_rtD(rtD), .AwriteD(wrD),
        .md_useD(mdUseD), .md_startE(mdStartE), .md_busy(mdBusy),
        .stall(nStall), .fwd_rsD(nFwdRsD), .fwd_rtD(nFwdRtD),
        .fwd_rsE(nFwdRsE), .fwd_rtE(nFwdRtE), .fwd_rtM(nFwdRtM),
        .A_writeE(nWriteE), .A_writeM(nWriteM), .A_writeW(nWriteW)
    );

    typedef struct {
        logic [1:0] tRs, tRt, tn;
        logic [4:0] rs, rt, wr;
        logic       mdU, mdS, mdB;
        logic       eStall, eStallNoMd;
        logic [1:0] eRsD, eRtD, eRsE, eRtE;
        logic       eRtM;
        logic [4:0] eWE, eWM, eWW;
    } vecT;

    vecT vecs[$];

    // Argument order: inputs (tuseRs, tuseRt, tnewD, rs, rt, wr, mdUse, mdStart, mdBusy),
    // then expected (stall, stallNoMd, fwdRsD, fwdRtD, fwdRsE, fwdRtE, fwdRtM, wE, wM, wW).
    function automatic vecT mk(int tRs, int tRt, int tn, int rs, int rt, int wr,
                               int mdU, int mdS, int mdB, int st, int stNo,
                               int fRsD, int fRtD, int fRsE, int fRtE, int fRtM,
                               int wE, int wM, int wW);
        vecT v;
        v.tRs = 2'(tRs);  v.tRt = 2'(tRt);  v.tn = 2'(tn);
        v.rs = 5'(rs);    v.rt = 5'(rt);    v.wr = 5'(wr);
        v.mdU = 1'(mdU);  v.mdS = 1'(mdS);  v.mdB = 1'(mdB);
        v.eStall = 1'(st); v.eStallNoMd = 1'(stNo);
        v.eRsD = 2'(fRsD); v.eRtD = 2'(fRtD); v.eRsE = 2'(fRsE); v.eRtE = 2'(fRtE);
        v.eRtM = 1'(fRtM);
        v.eWE = 5'(wE);   v.eWM = 5'(wM);   v.eWW = 5'(wW);
        return v;
    endfunction

    function automatic vecT nop(int st, int fRsD, int fRtD, int fRsE, int fRtE, int fRtM,
                                int wE, int wM, int wW);
        return mk(3, 3, 0, 0, 0, 0, 0, 0, 0, st, st, fRsD, fRtD, fRsE, fRtE, fRtM, wE, wM, wW);
    endfunction

    task automatic checkOne(string name, int actual, int expected);
        checks++;
        if (actual == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkOutput(string tag, int eSt, int eRsD, int eRtD, int eRsE,
                               int eRtE, int eRtM, int eWE, int eWM, int eWW);
        checkOne({tag, ".stall"},    int'(stall),   eSt);
        checkOne({tag, ".fwdRsD"},   int'(fwdRsD),  eRsD);
        checkOne({tag, ".fwdRtD"},   int'(fwdRtD),  eRtD);
        checkOne({tag, ".fwdRsE"},   int'(fwdRsE),  eRsE);
        checkOne({tag, ".fwdRtE"},   int'(fwdRtE),  eRtE);
        checkOne({tag, ".fwdRtM"},   int'(fwdRtM),  eRtM);
        checkOne({tag, ".aWriteE"},  int'(aWriteE), eWE);
        checkOne({tag, ".aWriteM"},  int'(aWriteM), eWM);
        checkOne({tag, ".aWriteW"},  int'(aWriteW), eWW);
    endtask

    task automatic applyStimulus(int tRs, int tRt, int tn, int rs, int rt, int wr,
                                 int mdU, int mdS, int mdB);
        tuseRs = 2'(tRs); tuseRt = 2'(tRt); tnewD = 2'(tn);
        rsD = 5'(rs);     rtD = 5'(rt);     wrD = 5'(wr);
        mdUseD = 1'(mdU); mdStartE = 1'(mdS); mdBusy = 1'(mdB);
    endtask

    // Reference model: each in-flight instruction is kept with its D-stage Tnew;
    // at age k (1=E, 2=M, 3=W) its remaining Tnew is max(TnewD - k, 0).
    typedef struct {
        logic [4:0] dst;
        int         tnew0;
        logic [4:0] rs;
        logic [4:0] rt;
    } instT;

    instT pipe [1:3];

    function automatic int tnewAt(int k);
        return (pipe[k].tnew0 > k) ? pipe[k].tnew0 - k : 0;
    endfunction

    function automatic bit hitAt(logic [4:0] a, int k);
        return (a != 5'd0) && (a == pipe[k].dst);
    endfunction

    function automatic bit needStall(int tuse, logic [4:0] a);
        if (tuse == 3) return 1'b0;
        return (hitAt(a, 1) && tnewAt(1) > tuse) || (hitAt(a, 2) && tnewAt(2) > tuse);
    endfunction

    function automatic int selD(logic [4:0] a);
        if (hitAt(a, 1) && tnewAt(1) == 0) return 1;
        if (hitAt(a, 2) && tnewAt(2) == 0) return 2;
        return 0;
    endfunction

    function automatic int selE(logic [4:0] a);
        if (hitAt(a, 2) && tnewAt(2) == 0) return 1;
        if (hitAt(a, 3)) return 2;
        return 0;
    endfunction

    task automatic modelClear();
        for (int k = 1; k <= 3; k++) begin
            pipe[k] = '{dst: 5'd0, tnew0: 0, rs: 5'd0, rt: 5'd0};
        end
    endtask

    task automatic randomPhase(int cycles);
        int eSt;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                          int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                          int'($urandom_range(0, 3) == 0), int'($urandom_range(0, 3) == 0),
                          int'($urandom_range(0, 3) == 0));
            eSt = int'(needStall(int'(tuseRs), rsD) || needStall(int'(tuseRt), rtD) ||
                       (mdUseD && (mdBusy || mdStartE)));
            #1;
            checkOutput($sformatf("rand%0d", n), eSt, selD(rsD), selD(rtD),
                        selE(pipe[1].rs), selE(pipe[1].rt), int'(hitAt(pipe[2].rt, 3)),
                        int'(pipe[1].dst), int'(pipe[2].dst), int'(pipe[3].dst));
            pipe[3] = pipe[2];
            pipe[2] = pipe[1];
            if (eSt != 0) begin
                pipe[1] = '{dst: 5'd0, tnew0: 0, rs: 5'd0, rt: 5'd0};
            end else begin
                pipe[1] = '{dst: wrD, tnew0: int'(tnewD), rs: rsD, rt: rtD};
            end
        end
    endtask

    initial begin
        // Reset held with arbitrary non-MD inputs: every output must read zero.
        reset = 1'b0;
        applyStimulus(3, 3, 0, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 31)),
                          int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 0, 0, 0);
            #1;
            checkOutput($sformatf("reset%0d", n), 0, 0, 0, 0, 0, 0, 0, 0, 0);
        end
        applyStimulus(3, 3, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;

        vecs.push_back(nop(0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(nop(0, 0, 0, 0, 0, 0, 0, 0, 0));
        // addu $3 then beq $3: one stall, then forward from M.
        vecs.push_back(mk(1, 1, 2, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3, 0, 3, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 3, 0, 0));
        vecs.push_back(mk(0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 3, 0));
        vecs.push_back(nop(0, 0, 0, 2, 0, 0, 0, 0, 3));
        vecs.push_back(nop(0, 0, 0, 0, 0, 0, 0, 0, 0));
        // addu $3 then addu reading $3 (Tuse 1): no stall, E takes M forward.
        vecs.push_back(mk(1, 1, 2, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3, 2, 3, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0));
        vecs.push_back(nop(0, 0, 0, 1, 0, 0, 4, 3, 0));
        vecs.push_back(nop(0, 0, 0, 0, 0, 0, 0, 4, 3));
        vecs.push_back(nop(0, 0, 0, 0, 0, 0, 0, 0, 4));
        vecs.push_back(nop(0, 0, 0, 0, 0, 0, 0, 0, 0));
        // lw $5 then addu reading $5: one stall, bubble in E, W forward later.
        vecs.push_back(mk(1, 3, 3, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 2, 5, 6, 8, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 5, 0, 0));
        vecs.push_back(mk(1, 1, 2, 5, 6, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0));
        vecs.push_back(nop(0, 0, 0, 2, 0, 0, 8, 0, 5));
        vecs.push_back(nop(0, 0, 0, 0, 0, 0, 0, 8, 0));
        vecs.push_back(nop(0, 0, 0, 0, 0, 0, 0, 0, 8));
        vecs.push_back(nop(0, 0, 0, 0, 0, 0, 0, 0, 0));
        // sw $7 right after addu $7: E forward from M, then M store forward from W.
        vecs.push_back(mk(1, 1, 2, 1, 2, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2, 0, 4, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0));
        vecs.push_back(nop(0, 0, 0, 0, 1, 0, 0, 7, 0));
        vecs.push_back(nop(0, 0, 0, 0, 0, 1, 0, 0, 7));
        vecs.push_back(nop(0, 0, 0, 0, 0, 0, 0, 0, 0));
        // sw $7 with one instruction in between.
        vecs.push_back(mk(1, 1, 2, 1, 2, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 2, 1, 2, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0));
        vecs.push_back(mk(1, 2, 0, 4, 7, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 9, 7, 0));
        vecs.push_back(nop(0, 0, 0, 0, 2, 0, 0, 9, 7));
        vecs.push_back(nop(0, 0, 0, 0, 0, 0, 0, 0, 9));
        vecs.push_back(nop(0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Writes to $0 never stall or forward.
        vecs.push_back(mk(1, 3, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(nop(0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(nop(0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Both E and M write $3 with E ready: E wins.
        vecs.push_back(mk(1, 1, 2, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0));
        vecs.push_back(mk(0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3, 3, 0));
        vecs.push_back(nop(0, 0, 0, 1, 0, 0, 0, 3, 3));
        vecs.push_back(nop(0, 0, 0, 0, 0, 0, 0, 0, 3));
        vecs.push_back(nop(0, 0, 0, 0, 0, 0, 0, 0, 0));
        // mfhi with md_busy for 5 cycles; the MD_STALL_EN=0 copy never stalls.
        for (int n = 0; n < 5; n++) begin
            vecs.push_back(mk(3, 3, 2, 0, 0, 10, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        vecs.push_back(mk(3, 3, 2, 0, 0, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(nop(0, 0, 0, 0, 0, 0, 10, 0, 0));
        vecs.push_back(nop(0, 0, 0, 0, 0, 0, 0, 10, 0));
        vecs.push_back(nop(0, 0, 0, 0, 0, 0, 0, 0, 10));
        vecs.push_back(mk(3, 3, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(3, 3, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(nop(0, 0, 0, 0, 0, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(int'(vecs[i].tRs), int'(vecs[i].tRt), int'(vecs[i].tn),
                          int'(vecs[i].rs), int'(vecs[i].rt), int'(vecs[i].wr),
                          int'(vecs[i].mdU), int'(vecs[i].mdS), int'(vecs[i].mdB));
            #1;
            checkOutput($sformatf("vec%0d", i), int'(vecs[i].eStall),
                        int'(vecs[i].eRsD), int'(vecs[i].eRtD), int'(vecs[i].eRsE),
                        int'(vecs[i].eRtE), int'(vecs[i].eRtM),
                        int'(vecs[i].eWE), int'(vecs[i].eWM), int'(vecs[i].eWW));
            checkOne($sformatf("vec%0d.stallNoMd", i), int'(nStall), int'(vecs[i].eStallNoMd));
        end

        // Reset asserted in the middle of a load-use stall.
        @(negedge clk);
        applyStimulus(1, 3, 3, 1, 0, 5, 0, 0, 0);
        @(negedge clk);
        applyStimulus(1, 1, 2, 5, 6, 8, 0, 0, 0);
        #1;
        checkOne("midReset.stallBefore", int'(stall), 1);
        checkOne("midReset.aWriteEBefore", int'(aWriteE), 5);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midReset.after", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        mdUseD = 1'b1;
        mdBusy = 1'b1;
        #1;
        checkOne("midReset.mdBusyStall", int'(stall), 1);
        applyStimulus(3, 3, 0, 0, 0, 0, 0, 0, 0);
        modelClear();
        @(negedge clk);
        reset = 1'b1;

        randomPhase(400);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
